// File: rtl/fpu_conv_sched.sv
// Round-robin scheduler that shares one fixed-latency int/float conversion
// datapath between several requesters and routes each result back to its issuer.
module fpu_conv_sched #(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 2,
  parameter int C_OP    = 32
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_RBI,
  input  logic [NUM_REQ-1:0]      Req_valid_SI,
  output logic [NUM_REQ-1:0]      Req_ready_SO,
  input  logic [NUM_REQ*C_OP-1:0] Req_operand_DI,
  input  logic                    Stall_SI,
  output logic [C_OP-1:0]         Dp_operand_DO,
  output logic                    Dp_valid_SO,
  output logic                    Dp_en_SO,
  input  logic [C_OP-1:0]         Dp_result_DI,
  output logic [NUM_REQ-1:0]      Res_valid_SO,
  output logic [C_OP-1:0]         Res_result_DO,
  output logic                    Busy_SO
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     grant_id;
  logic               grant_found;
  logic [IDW:0]       cand;
  logic [C_OP-1:0]    grant_operand;
  logic [IDW-1:0]     next_ptr;
  logic [NUM_REQ-1:0] res_onehot;
  logic [LATENCY:0]   stage_valid;
  logic [IDW-1:0]     stage_id [0:LATENCY];

  // Search from the pointer upward, wrapping, and take the first valid requester.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!grant_found && Req_valid_SI[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    Req_ready_SO  = '0;
    grant_operand = '0;
    res_onehot    = '0;
    if (grant_found && !Stall_SI) begin
      Req_ready_SO[grant_id] = 1'b1;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDW'(k) == grant_id) begin
        grant_operand = Req_operand_DI[k*C_OP +: C_OP];
      end
    end
    res_onehot[stage_id[LATENCY]] = 1'b1;
    next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);
  end

  // A stall freezes everything except the result strobe, which must not repeat.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      rr_ptr        <= '0;
      stage_valid   <= '0;
      Dp_operand_DO <= '0;
      Res_valid_SO  <= '0;
      Res_result_DO <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        stage_id[i] <= '0;
      end
    end else if (Stall_SI) begin
      Res_valid_SO <= '0;
    end else begin
      stage_valid <= {stage_valid[LATENCY-1:0], grant_found};
      stage_id[0] <= grant_id;
      for (int i = 1; i <= LATENCY; i++) begin
        stage_id[i] <= stage_id[i-1];
      end
      Res_valid_SO <= stage_valid[LATENCY] ? res_onehot : '0;
      if (stage_valid[LATENCY]) begin
        Res_result_DO <= Dp_result_DI;
      end
      if (grant_found) begin
        Dp_operand_DO <= grant_operand;
        rr_ptr        <= next_ptr;
      end
    end
  end

  assign Dp_valid_SO = stage_valid[0];
  assign Dp_en_SO    = ~Stall_SI;
  assign Busy_SO     = |stage_valid;

endmodule

// File: tb/tb_fpu_conv_sched.sv
// Bench for fpu_conv_sched: directed scenarios plus random traffic, checked
// every cycle against an issue-queue model and a datapath of operand+1.
module tb_fpu_conv_sched;

  localparam int N   = 2;
  localparam int LAT = 2;
  localparam int W   = 32;

  logic              Clk_CI = 1'b0;
  logic              Rst_RBI;
  logic [N-1:0]      Req_valid_SI;
  logic [N-1:0]      Req_ready_SO;
  logic [N*W-1:0]    Req_operand_DI;
  logic              Stall_SI;
  logic [W-1:0]      Dp_operand_DO;
  logic              Dp_valid_SO;
  logic              Dp_en_SO;
  logic [W-1:0]      Dp_result_DI;
  logic [N-1:0]      Res_valid_SO;
  logic [W-1:0]      Res_result_DO;
  logic              Busy_SO;

  int checks   = 0;
  int failures = 0;

  fpu_conv_sched #(.NUM_REQ(N), .LATENCY(LAT), .C_OP(W)) dut (
    .Clk_CI        (Clk_CI),
    .Rst_RBI       (Rst_RBI),
    .Req_valid_SI  (Req_valid_SI),
    .Req_ready_SO  (Req_ready_SO),
    .Req_operand_DI(Req_operand_DI),
    .Stall_SI      (Stall_SI),
    .Dp_operand_DO (Dp_operand_DO),
    .Dp_valid_SO   (Dp_valid_SO),
    .Dp_en_SO      (Dp_en_SO),
    .Dp_result_DI  (Dp_result_DI),
    .Res_valid_SO  (Res_valid_SO),
    .Res_result_DO (Res_result_DO),
    .Busy_SO       (Busy_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  // Stand-in conversion datapath: LAT enabled stages computing operand+1.
  logic [W-1:0] dp_pipe [0:LAT-1] = '{default: '0};
  always @(posedge Clk_CI) begin
    if (Dp_en_SO) begin
      dp_pipe[0] <= Dp_operand_DO + 32'd1;
      for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
  end
  assign Dp_result_DI = dp_pipe[LAT-1];

  typedef struct {
    int           id;
    logic [W-1:0] res;
    int           age;
  } entry_t;

  entry_t       inflight[$];
  int           m_ptr      = 0;
  logic [N-1:0] exp_valid  = '0;
  logic [W-1:0] exp_result = '0;
  bit           model_live = 0;

  function automatic int winner(input int ptr, input logic [N-1:0] v);
    logic [N-1:0] sh;
    for (int k = 0; k < N; k++) begin
      sh = v >> ((ptr + k) % N);
      if (sh[0]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every op ages once per non-stalled edge and retires after LAT+1 of them.
  always @(posedge Clk_CI) begin
    int           w;
    entry_t       e;
    logic [N*W-1:0] sh;
    if (!Rst_RBI) begin
      inflight.delete();
      m_ptr      = 0;
      exp_valid  = '0;
      exp_result = '0;
      model_live = 1;
    end else if (Stall_SI) begin
      exp_valid = '0;
    end else begin
      exp_valid = '0;
      foreach (inflight[i]) inflight[i].age++;
      if (inflight.size() > 0 && inflight[0].age == LAT + 1) begin
        exp_valid  = N'(1) << inflight[0].id;
        exp_result = inflight[0].res;
        void'(inflight.pop_front());
      end
      w = winner(m_ptr, Req_valid_SI);
      if (w >= 0) begin
        sh    = Req_operand_DI >> (w * W);
        e.id  = w;
        e.res = sh[W-1:0] + 32'd1;
        e.age = 0;
        inflight.push_back(e);
        m_ptr = (w + 1) % N;
      end
    end
  end

  always @(negedge Clk_CI) begin
    int           w;
    logic [N-1:0] er;
    if (model_live) begin
      w  = winner(m_ptr, Req_valid_SI);
      er = (w >= 0 && !Stall_SI) ? N'(1) << w : '0;
      checkOutput("ready",  64'(Req_ready_SO),  64'(er));
      checkOutput("res_valid", 64'(Res_valid_SO), 64'(exp_valid));
      checkOutput("res_result", 64'(Res_result_DO), 64'(exp_result));
      checkOutput("busy",   64'(Busy_SO), 64'(inflight.size() != 0));
      checkOutput("dp_en",  64'(Dp_en_SO), 64'(!Stall_SI));
    end
  end

  // Inputs change just after a rising edge and are sampled at the next one.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [W-1:0] o0,
                               input logic [W-1:0] o1, input logic st, input logic rn);
    @(posedge Clk_CI);
    #1;
    Req_valid_SI   = v;
    Req_operand_DI = {o1, o0};
    Stall_SI       = st;
    Rst_RBI        = rn;
  endtask

  initial begin
    Rst_RBI        = 1'b0;
    Req_valid_SI   = '0;
    Req_operand_DI = '0;
    Stall_SI       = 1'b0;
    applyStimulus(2'b00, 0, 0, 0, 0);
    applyStimulus(2'b00, 0, 0, 0, 0);

    $display("[TB] single request");
    applyStimulus(2'b01, 32'h5, 0, 0, 1);
    applyStimulus(2'b00, 0, 0, 0, 1);
    repeat (3) @(posedge Clk_CI);
    @(negedge Clk_CI);
    checkOutput("single_valid", 64'(Res_valid_SO), 64'h1);
    checkOutput("single_result", 64'(Res_result_DO), 64'h6);
    checkOutput("single_busy", 64'(Busy_SO), 64'h0);

    $display("[TB] round robin");
    applyStimulus(2'b00, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'b11, 32'h10, 32'h20, 0, 1);
      @(negedge Clk_CI);
      checkOutput("rr_grant", 64'(Req_ready_SO), (k % 2) ? 64'h2 : 64'h1);
      if (k >= 4) begin
        checkOutput("rr_res_valid", 64'(Res_valid_SO), (k % 2) ? 64'h2 : 64'h1);
        checkOutput("rr_res", 64'(Res_result_DO), (k % 2) ? 64'h21 : 64'h11);
      end
    end
    applyStimulus(2'b00, 0, 0, 0, 1);
    for (int j = 2; j < 6; j++) begin
      if (j > 2) @(posedge Clk_CI);
      @(negedge Clk_CI);
      checkOutput("rr_res_valid", 64'(Res_valid_SO), (j % 2) ? 64'h2 : 64'h1);
      checkOutput("rr_res", 64'(Res_result_DO), (j % 2) ? 64'h21 : 64'h11);
    end

    $display("[TB] back to back");
    for (int k = 0; k < 4; k++) applyStimulus(2'b10, 0, W'(k + 1), 0, 1);
    applyStimulus(2'b00, 0, 0, 0, 1);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(posedge Clk_CI);
      @(negedge Clk_CI);
      checkOutput("b2b_valid", 64'(Res_valid_SO), 64'h2);
      checkOutput("b2b_result", 64'(Res_result_DO), 64'(j + 2));
    end

    $display("[TB] stall mid-flight");
    applyStimulus(2'b01, 32'h7, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b10, 0, 32'h9, 1, 1);
      @(negedge Clk_CI);
      checkOutput("stall_ready", 64'(Req_ready_SO), 64'h0);
    end
    applyStimulus(2'b00, 0, 0, 0, 1);
    repeat (2) @(posedge Clk_CI);
    @(negedge Clk_CI);
    checkOutput("stall_early", 64'(Res_valid_SO), 64'h0);
    @(posedge Clk_CI);
    @(negedge Clk_CI);
    checkOutput("stall_valid", 64'(Res_valid_SO), 64'h1);
    checkOutput("stall_result", 64'(Res_result_DO), 64'h8);
    @(posedge Clk_CI);
    @(negedge Clk_CI);
    checkOutput("stall_nodup", 64'(Res_valid_SO), 64'h0);

    $display("[TB] reset mid-operation");
    applyStimulus(2'b11, 32'h30, 32'h40, 0, 1);
    applyStimulus(2'b11, 32'h30, 32'h40, 0, 1);
    applyStimulus(2'b00, 0, 0, 0, 0);
    applyStimulus(2'b00, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk_CI);
      checkOutput("rst_no_res", 64'(Res_valid_SO), 64'h0);
      checkOutput("rst_busy", 64'(Busy_SO), 64'h0);
      @(posedge Clk_CI);
    end
    applyStimulus(2'b11, 32'h50, 32'h60, 0, 1);
    @(negedge Clk_CI);
    checkOutput("rst_ptr", 64'(Req_ready_SO), 64'h1);

    $display("[TB] idle/drop while stalled");
    applyStimulus(2'b01, 32'h55, 0, 1, 1);
    applyStimulus(2'b00, 0, 0, 0, 1);
    repeat (6) @(posedge Clk_CI);
    applyStimulus(2'b11, 32'h70, 32'h80, 0, 1);
    @(negedge Clk_CI);
    checkOutput("drop_ptr", 64'(Req_ready_SO), 64'h2);

    $display("[TB] random traffic");
    for (int k = 0; k < 600; k++) begin
      applyStimulus(N'($urandom_range(0, 3)), $urandom, $urandom,
                    ($urandom_range(0, 99) < 15), !($urandom_range(0, 99) < 2));
    end
    repeat (10) applyStimulus(2'b00, 0, 0, 0, 1);
    @(negedge Clk_CI);
    checkOutput("final_busy", 64'(Busy_SO), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_conv_sched.md
Name: fpu_conv_sched

Overview:
- Shares one fixed-latency int/float conversion datapath (itof prenorm + normalizer/rounder) between NUM_REQ requesters (core FP units, vector lanes).
- Round-robin arbitration with a valid/ready handshake per requester.
- Tracks in-flight operations with a valid/ID shift pipeline and routes each result back to its originator.
- Global stall freezes the whole datapath.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- LATENCY, 2, datapath register stages between Dp_operand_DO and Dp_result_DI (1..4)
- C_OP, 32, operand/result width (from fpu_defs)

Ports:
- Clk_CI  in  1  clock
- Rst_RBI  in  1  synchronous active-low reset
- Req_valid_SI  in  NUM_REQ  per-requester request valid
- Req_ready_SO  out  NUM_REQ  per-requester grant/accept
- Req_operand_DI  in  NUM_REQ*C_OP  packed operands; requester i uses bits [i*C_OP +: C_OP]
- Stall_SI  in  1  global pipeline freeze
- Dp_operand_DO  out  C_OP  registered operand to the datapath
- Dp_valid_SO  out  1  Dp_operand_DO holds a live operation
- Dp_en_SO  out  1  datapath stage enable; equals ~Stall_SI
- Dp_result_DI  in  C_OP  datapath output, meaningful when the last tracking stage is valid
- Res_valid_SO  out  NUM_REQ  one-hot result strobe
- Res_result_DO  out  C_OP  registered result
- Busy_SO  out  1  any operation in flight

Behaviour:
- Reset (Rst_RBI=0 at a rising edge): clear all tracking valids, result valid, Dp_valid_SO and Res_valid_SO. Set Dp_operand_DO and Res_result_DO to 0. Set the RR pointer to 0, so requester 0 has highest priority. Reset mid-operation discards every in-flight op; no result is emitted.
- Arbitration (combinational):
  - Search requesters starting at the pointer and wrapping modulo NUM_REQ.
  - The first asserted Req_valid_SI wins.
  - Req_ready_SO is one-hot on the winner, gated by ~Stall_SI. It is all-zero when stalled or when there are no requests.
  - Ready never depends on downstream results; there is no backpressure other than Stall_SI.
- Issue (edge where winner i has valid&ready):
  - Dp_operand_DO <= operand i; Dp_valid_SO <= 1.
  - Tracking stage 0 <= {1, i}.
  - Pointer <= (i+1) mod NUM_REQ.
  - With no issue and no stall, Dp_valid_SO <= 0 and stage 0 valid <= 0. The pointer holds when no handshake occurs.
- Tracking pipeline:
  - Stages 0..LATENCY, each {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Shifts one stage per non-stalled edge, in lockstep with the datapath.
  - Stage 0 aligns with Dp_operand_DO. Stage LATENCY aligns with Dp_result_DI.
- Result stage (non-stalled edge):
  - Res_result_DO <= Dp_result_DI when stage LATENCY is valid; otherwise it holds.
  - Res_valid_SO <= onehot(id) if stage LATENCY is valid, else 0.
- Latency: handshake at edge t → Res_valid_SO high for exactly one cycle, in cycle t+LATENCY+1, when no stall occurs. Throughput is 1 op/cycle.
- Stall (Stall_SI=1 at an edge):
  - All tracking stages, Dp_operand_DO, Dp_valid_SO and the pointer hold.
  - Res_valid_SO <= 0 and Res_result_DO holds.
  - No issue occurs.
  - Each op's result latency grows by the number of stalled edges; results are never duplicated or lost.
- Ordering: results return in issue order.
- Busy_SO = OR of all tracking valids and Dp_valid_SO (combinational from registers).
- Simultaneous requests: exactly one grant per cycle. A requester holding valid is granted within NUM_REQ non-stalled cycles (starvation-free).
- A requester may drop valid without a grant; the operand must be stable only during the handshake cycle.

Test Plan:
- Reset then a single request: NUM_REQ=2, LATENCY=2; datapath modelled as a 2-stage delay of operand+1. Req0 with 0x00000005 at edge t → Res_valid_SO=2'b01, Res_result_DO=0x00000006 in cycle t+3. Busy_SO low after.
- Round robin under contention: Req0 and Req1 held valid for 6 cycles, operands 0x10/0x20 → grants alternate 0,1,0,1,0,1 from reset. Results alternate 0x11/0x21 with matching one-hot strobes.
- Back-to-back single requester: Req1 valid for 4 cycles with operands 1,2,3,4 → 4 consecutive Res_valid_SO=2'b10 with results 2,3,4,5. No bubbles.
- Stall mid-flight: issue 0x7, assert Stall_SI for 3 edges at t+1 → Req_ready_SO=0 throughout. Single result 0x8 strobed in cycle t+6. No duplicates.
- Reset mid-operation: 2 ops in flight, Rst_RBI=0 for one edge → no Res_valid_SO afterwards, Busy_SO=0, pointer=0 (Req0 wins the next contention).
- Idle/drop: Req0 valid for one cycle while stalled, then dropped → no issue, no result, pointer unchanged.
